// File: rtl/reg_wb_scoreboard.sv
// Scoreboard of outstanding register writes between issue and write-back; raises RAW/saturation stalls.
// Optional macro WB_BYPASS_EN: a read of a register retiring its last outstanding write this cycle does not stall.
module reg_wb_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_wreg,
  input  logic [4:0]      src_a,
  input  logic            src_a_used,
  input  logic [4:0]      src_b,
  input  logic            src_b_used,
  input  logic            wb_valid,
  input  logic [4:0]      wb_wreg,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic            underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0][CNT_W-1:0] cnt_nxt;
  logic [NREG-1:0]            pending_nxt;
  logic                       haz_a, haz_b, sat;
  logic                       byp_a, byp_b;
  logic                       issue_fire, wb_fire, same_reg, underflow_set;

  always_comb begin
    wb_fire = wb_valid && (wb_wreg != 5'd0);
    haz_a   = src_a_used && (src_a != 5'd0) && (cnt[src_a] != '0);
    haz_b   = src_b_used && (src_b != 5'd0) && (cnt[src_b] != '0);
`ifdef WB_BYPASS_EN
    // The register file writes through, so the last retiring write can be read this cycle.
    byp_a   = wb_fire && (wb_wreg == src_a) && (cnt[src_a] == CNT_ONE);
    byp_b   = wb_fire && (wb_wreg == src_b) && (cnt[src_b] == CNT_ONE);
`else
    byp_a   = 1'b0;
    byp_b   = 1'b0;
`endif
    sat        = issue_we && (issue_wreg != 5'd0) && (cnt[issue_wreg] == CNT_MAX);
    stall      = issue_valid && ((haz_a && !byp_a) || (haz_b && !byp_b) || sat);
    issue_fire = issue_valid && !stall && issue_we && (issue_wreg != 5'd0);
    same_reg   = issue_fire && wb_fire && (issue_wreg == wb_wreg);
    underflow_set = wb_fire && !same_reg && (cnt[wb_wreg] == '0);
  end

  // Issue and write-back to the same register cancel, even from a zero count.
  always_comb begin
    cnt_nxt     = cnt;
    pending_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!same_reg) begin
        if (issue_fire && (issue_wreg == 5'(i)))
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        if (wb_fire && (wb_wreg == 5'(i)) && (cnt[i] != '0))
          cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      pending_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      pending       <= '0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      cnt           <= '0;
      pending       <= '0;
    end else begin
      cnt           <= cnt_nxt;
      pending       <= pending_nxt;
      if (underflow_set)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Self-checking bench for reg_wb_scoreboard: directed scenarios then random traffic against a counting model.
module tb_reg_wb_scoreboard;

  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n, issue_valid, issue_we, src_a_used, src_b_used, wb_valid, flush;
  logic [4:0]  issue_wreg, src_a, src_b, wb_wreg;
  logic        stall, underflow_err;
  logic [31:0] pending;

  int mcnt [NREG];
  logic muf;
  int nAsserts = 0;
  int nFails   = 0;

  reg_wb_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_wreg(issue_wreg), .src_a(src_a), .src_a_used(src_a_used),
    .src_b(src_b), .src_b_used(src_b_used), .wb_valid(wb_valid),
    .wb_wreg(wb_wreg), .flush(flush), .stall(stall), .pending(pending),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic srcHaz(input logic [4:0] s, input logic used);
    logic h;
    h = used && (s != 0) && (mcnt[s] > 0);
`ifdef WB_BYPASS_EN
    if (wb_valid && wb_wreg != 0 && wb_wreg == s && mcnt[s] == 1) h = 1'b0;
`endif
    return h;
  endfunction

  function automatic logic modelStall();
    logic sat;
    sat = issue_we && (issue_wreg != 0) && (mcnt[issue_wreg] == MAXC);
    return issue_valid && (srcHaz(src_a, src_a_used) || srcHaz(src_b, src_b_used) || sat);
  endfunction

  function automatic logic [31:0] expPending();
    logic [31:0] p;
    for (int i = 0; i < NREG; i++) p[i] = (mcnt[i] > 0);
    return p;
  endfunction

  task automatic modelUpdate(input logic st);
    logic fire, wbf;
    fire = issue_valid && !st && issue_we && (issue_wreg != 0);
    wbf  = wb_valid && (wb_wreg != 0);
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mcnt[i] = 0;
      muf = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) mcnt[i] = 0;
    end else if (!(fire && wbf && issue_wreg == wb_wreg)) begin
      if (fire) mcnt[issue_wreg] = mcnt[issue_wreg] + 1;
      if (wbf) begin
        if (mcnt[wb_wreg] > 0) mcnt[wb_wreg] = mcnt[wb_wreg] - 1;
        else muf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic iv, input logic we, input logic [4:0] wr,
                               input logic [4:0] sa, input logic sau, input logic [4:0] sb,
                               input logic sbu, input logic wv, input logic [4:0] wbr, input logic fl);
    rst_n = rn; issue_valid = iv; issue_we = we; issue_wreg = wr;
    src_a = sa; src_a_used = sau; src_b = sb; src_b_used = sbu;
    wb_valid = wv; wb_wreg = wbr; flush = fl;
  endtask

  // Inputs are set just after a falling edge; stall is checked before the rising edge, state after it.
  task automatic runCycle(input string tag);
    logic es;
    #2;
    es = modelStall();
    checkOutput({tag, "_stall"}, {31'b0, stall}, {31'b0, es});
    @(posedge clk);
    modelUpdate(es);
    #1;
    checkOutput({tag, "_pend"}, pending, expPending());
    checkOutput({tag, "_uf"}, {31'b0, underflow_err}, {31'b0, muf});
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mcnt[i] = 0;
    muf = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    runCycle("rst0");
    runCycle("rst1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("idle");
    checkOutput("idle_pend0", pending, 32'h0);

    // Single RAW on register 5
    applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    runCycle("raw_issue");
    applyStimulus(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("raw_stall_k", {31'b0, stall}, 32'd1);
    checkOutput("raw_pend5_k", {31'b0, pending[5]}, 32'd1);
    runCycle("raw_hold");
    applyStimulus(1, 1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
`ifdef WB_BYPASS_EN
    #1 checkOutput("raw_wb_stall_k", {31'b0, stall}, 32'd0);
`else
    #1 checkOutput("raw_wb_stall_k", {31'b0, stall}, 32'd1);
`endif
    runCycle("raw_wb");
    checkOutput("raw_pend5_clr_k", {31'b0, pending[5]}, 32'd0);
    applyStimulus(1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    runCycle("raw_after");

    // Saturation on register 7
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      runCycle("sat_fill");
    end
    applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("sat_stall_k", {31'b0, stall}, 32'd1);
    runCycle("sat_full");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    runCycle("sat_wb");
    applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("sat_accept_k", {31'b0, stall}, 32'd0);
    runCycle("sat_accept");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle("flush0");

    // Register 0 is never tracked
    applyStimulus(1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    runCycle("r0");
    checkOutput("r0_pend_k", pending, 32'h0);

    // Simultaneous issue and write-back
    applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    runCycle("sim_issue9");
    applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 1, 9, 0);
    runCycle("sim_same");
    checkOutput("sim_same_p9_k", {31'b0, pending[9]}, 32'd1);
    applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 1, 9, 0);
    runCycle("sim_diff");
    checkOutput("sim_diff_k", {30'b0, pending[9], pending[3]}, 32'd1);

    // Flush then underflow
    applyStimulus(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    runCycle("fl_i4");
    applyStimulus(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    runCycle("fl_i6");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle("fl_flush");
    checkOutput("fl_pend_k", pending, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    runCycle("uf_wb");
    checkOutput("uf_set_k", {31'b0, underflow_err}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle("uf_hold");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("uf_rst");
    checkOutput("uf_clr_k", {31'b0, underflow_err}, 32'd0);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 59) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                    5'($urandom_range(0, 7)), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
      runCycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
